id_ex_alu_issue: RTL
====================

// Module: id_ex_alu_issue
// PURPOSE
//  ID/EX pipeline stage feeding the execute-stage ALU: decodes the ID instruction into the ALU opcode, selects
//  operands A/B and registers them for EX. Holds on stall, bubbles on flush, flags illegal ALU encodings.
//  Producer end of the ALU interface {A, B, alu_op}; EX consumes outputs directly, no extra logic.
// PARAMETERS
//  XLEN            32  datapath width; only 32 supported
//  MASK_SHAMT      1   1: B forced to {27'b0, shamt[4:0]} for shift ops (ALU shifts by full B)
//  ILLEGAL_BUBBLE  0   1: illegal instr issues ex_valid=0; 0: issues valid with ex_illegal=1
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   reset, asynchronous, active-low
//  id_valid     in   1   ID slot holds a real instruction
//  id_instr     in   32  instruction word
//  id_pc        in   32  instruction PC
//  id_rs1_data  in   32  rs1 value (already forwarded)
//  id_rs2_data  in   32  rs2 value (already forwarded)
//  stall        in   1   hold EX register contents
//  flush        in   1   insert bubble into EX
//  ex_valid     out  1   EX slot valid
//  ex_a         out  32  ALU operand A
//  ex_b         out  32  ALU operand B
//  ex_alu_op    out  4   ALU opcode: ADD 0000 SUB 1000 SLL 0001 SRL 0101 SRA 1101 SLT 0010 SLTU 0011 XOR 0100 OR 0110 AND 0111
//  ex_illegal   out  1   registered instr had no legal ALU mapping
// BEHAVIOUR
//  - Reset (rst_n=0, async, any time incl. mid-stream): all outputs 0 (ex_alu_op=ADD). First update on first clk edge after release.
//  - Latency 1 cycle, all outputs registered. Per edge: flush -> bubble; else stall -> hold all; else load decode.
//  - flush beats stall when both asserted.
//  - Bubble / id_valid=0 load: ex_valid=0, ex_a=ex_b=0, ex_alu_op=0000, ex_illegal=0.
//  - Decode, op=instr[6:0], f3=instr[14:12], f7=instr[31:25]:
//    R 0110011: alu_op={f7[5],f3}; A=rs1, B=rs2. Legal only if f7=0000000, or f7=0100000 with f3 in {000,101}.
//    I 0010011: alu_op={f3==101 ? f7[5] : 0, f3}; A=rs1, B=sext(imm_i).
//      Shifts: f3=001 requires f7=0; f3=101 requires f7 in {0000000,0100000}.
//    LUI 0110111: ADD; A=0, B=imm_u. AUIPC 0010111: ADD; A=pc, B=imm_u.
//    LOAD 0000011: ADD, A=rs1, B=imm_i. STORE 0100011: ADD, A=rs1, B=imm_s.
//    BRANCH 1100011: A=rs1, B=rs2; f3 000/001 SUB; 100/101 SLT; 110/111 SLTU; 010/011 illegal.
//    JAL 1101111 / JALR 1100111: ADD, A=pc, B=32'd4 (link value).
//    Any other opcode: illegal.
//  - MASK_SHAMT=1 with alu_op in {SLL,SRL,SRA}: B upper 27 bits zeroed (R and I forms).
//  - Illegal: ex_alu_op=0000, ex_a=ex_b=0, ex_illegal=1; ex_valid=~ILLEGAL_BUBBLE.
//  - Imm: imm_i=sext(instr[31:20]); imm_s=sext({instr[31:25],instr[11:7]}); imm_u={instr[31:12],12'b0}.
//  - No internal state besides EX register; stall indefinitely long holds values unchanged.
// TESTING
//  1. add x3,x1,x2 0x002081B3, rs1=5, rs2=7, valid -> next cycle op=0000, a=5, b=7, valid=1, illegal=0.
//  2. sub 0x402081B3 -> op=1000; blt 0x0020C463, rs1=1, rs2=2 -> op=0010, a=1, b=2.
//  3. srai x1,x1,3 0x4030D093, rs1=0x80000000 -> op=1101, b=3; sll with rs2=0xFFFFFF21 -> b=1.
//  4. lui x5,0x12345 0x123452B7 -> op=0000, a=0, b=0x12345000; auipc with pc=0x100 -> a=0x100.
//  5. Load instr, stall=1 for 3 cycles with new id_* -> outputs frozen; stall=1+flush=1 -> valid=0, a=b=0.
//  6. 0x0000007F -> illegal=1, valid=1, op=0000; rst_n=0 between edges -> outputs 0 immediately.

Source files
------------

// File: rtl/id_ex_alu_issue.sv
// id_ex_alu_issue
//   ID/EX pipeline register for the execute-stage ALU. Decodes the ID-stage
//   instruction into a 4-bit ALU opcode, selects operands A/B and registers
//   them (1-cycle latency). EX consumes ex_a/ex_b/ex_alu_op directly.
//
//   Slot semantics: ex_valid=1 means the EX register holds a real instruction.
//   There is no back-pressure handshake; stall freezes the register, and flush
//   (which wins over stall) replaces its contents with a bubble.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   id_valid                   ID slot holds a real instruction
//   id_instr, id_pc            instruction word and its PC
//   id_rs1_data, id_rs2_data   forwarded register operands
//   stall, flush               hold EX register / insert bubble
//   ex_valid                   EX slot valid
//   ex_a, ex_b, ex_alu_op      ALU operands and opcode
//   ex_illegal                 registered instruction had no legal ALU mapping
module id_ex_alu_issue #(
  parameter int XLEN           = 32,
  parameter bit MASK_SHAMT     = 1'b1,
  parameter bit ILLEGAL_BUBBLE = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [31:0]     id_instr,
  input  logic [31:0]     id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic            stall,
  input  logic            flush,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [3:0]      ex_alu_op,
  output logic            ex_illegal
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_u;

  assign opcode = id_instr[6:0];
  assign f3     = id_instr[14:12];
  assign f7     = id_instr[31:25];
  assign imm_i  = {{20{id_instr[31]}}, id_instr[31:20]};
  assign imm_s  = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
  assign imm_u  = {id_instr[31:12], 12'b0};

  // Raw decode before illegal squashing
  logic [3:0]  raw_op;
  logic [31:0] raw_a, raw_b;
  logic        legal;
  logic        shift_form;

  // Final values to load into the EX register when not stalled/flushed
  logic        nxt_valid;
  logic [3:0]  nxt_op;
  logic [31:0] nxt_a, nxt_b;
  logic        nxt_illegal;

  always_comb begin
    raw_op     = OP_ADD;
    raw_a      = '0;
    raw_b      = '0;
    legal      = 1'b0;
    shift_form = 1'b0;
    unique case (opcode)
      7'b0110011: begin  // R-type
        raw_op     = {f7[5], f3};
        raw_a      = id_rs1_data;
        raw_b      = id_rs2_data;
        shift_form = 1'b1;
        legal      = (f7 == 7'b0000000) ||
                     (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
      end
      7'b0010011: begin  // I-type ALU; f7[5] only selects SRA for f3=101
        raw_op     = {(f3 == 3'b101) ? f7[5] : 1'b0, f3};
        raw_a      = id_rs1_data;
        raw_b      = imm_i;
        shift_form = 1'b1;
        if (f3 == 3'b001)      legal = (f7 == 7'b0000000);
        else if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        else                   legal = 1'b1;
      end
      7'b0110111: begin raw_a = '0;          raw_b = imm_u; legal = 1'b1; end  // LUI
      7'b0010111: begin raw_a = id_pc;       raw_b = imm_u; legal = 1'b1; end  // AUIPC
      7'b0000011: begin raw_a = id_rs1_data; raw_b = imm_i; legal = 1'b1; end  // LOAD
      7'b0100011: begin raw_a = id_rs1_data; raw_b = imm_s; legal = 1'b1; end  // STORE
      7'b1100011: begin  // BRANCH: compare rs1 against rs2
        raw_a = id_rs1_data;
        raw_b = id_rs2_data;
        legal = 1'b1;
        case (f3)
          3'b000, 3'b001: raw_op = OP_SUB;
          3'b100, 3'b101: raw_op = OP_SLT;
          3'b110, 3'b111: raw_op = OP_SLTU;
          default:        legal  = 1'b0;
        endcase
      end
      7'b1101111, 7'b1100111: begin  // JAL/JALR compute the link value pc+4
        raw_a = id_pc;
        raw_b = 32'd4;
        legal = 1'b1;
      end
      default: legal = 1'b0;
    endcase

    // The ALU shifts by the full B operand, so trim it to the shift amount
    if (MASK_SHAMT && shift_form &&
        (raw_op == OP_SLL || raw_op == OP_SRL || raw_op == OP_SRA))
      raw_b = {27'b0, raw_b[4:0]};

    nxt_valid   = 1'b0;
    nxt_op      = OP_ADD;
    nxt_a       = '0;
    nxt_b       = '0;
    nxt_illegal = 1'b0;
    if (id_valid) begin
      if (legal) begin
        nxt_valid = 1'b1;
        nxt_op    = raw_op;
        nxt_a     = raw_a;
        nxt_b     = raw_b;
      end else begin
        nxt_valid   = ~ILLEGAL_BUBBLE;
        nxt_illegal = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_a       <= '0;
      ex_b       <= '0;
      ex_alu_op  <= OP_ADD;
      ex_illegal <= 1'b0;
    end else if (flush) begin
      ex_valid   <= 1'b0;
      ex_a       <= '0;
      ex_b       <= '0;
      ex_alu_op  <= OP_ADD;
      ex_illegal <= 1'b0;
    end else if (!stall) begin
      ex_valid   <= nxt_valid;
      ex_a       <= nxt_a;
      ex_b       <= nxt_b;
      ex_alu_op  <= nxt_op;
      ex_illegal <= nxt_illegal;
    end
  end

endmodule
